regfile: RTL
============

Name: regfile

Overview:
- Operand register file sitting directly upstream of the datapath ALU.
- Holds 2**m registers of n bits and provides two synchronous read ports that drive the ALU A and B operand inputs.
- One write port takes write-back data from either the registered ALU result or an external data input.
- Read data is registered, so operands reach the ALU one cycle after a read request, ready for the ALU's enabled register stage.

Parameters:
- n, 8, data width; must equal the ALU n.
- m, 3, address width; register count is 2**m.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset: sampled on rising clk, clears state when 0.
- wd_sel  in  1  write-data select: 1 = din, 0 = alu_sum.
- din  in  n  external write data (load path).
- alu_sum  in  n  registered result from ALU (write-back path).
- write  in  1  write enable.
- waddr  in  m  write address.
- read_a  in  1  read enable, port A.
- raddr_a  in  m  read address, port A.
- read_b  in  1  read enable, port B.
- raddr_b  in  m  read address, port B.
- qa  out  n  port A data, to ALU A.
- qb  out  n  port B data, to ALU B.
- qa_valid  out  1  high the cycle after an accepted port-A read.
- qb_valid  out  1  high the cycle after an accepted port-B read.

Behaviour:
- Reset (rst=0 at clk edge):
  - all 2**m registers become 0.
  - qa, qb become 0.
  - qa_valid, qb_valid become 0.
  - Reset overrides any write or read in the same cycle.
  - Reset mid-sequence discards any pending read result.
- Write: if write=1 at the edge, reg[waddr] <= (wd_sel ? din : alu_sum).
  - Every address, including 0, is writable.
  - If write=0, nothing changes.
- Read port A:
  - if read_a=1 at the edge: qa <= reg[raddr_a] and qa_valid <= 1.
  - if read_a=0: qa holds its previous value and qa_valid <= 0.
  - Read latency is exactly 1 cycle.
- Port B is identical to port A and independent of it.
- Both ports may read the same address in the same cycle; both return the same value.
- Simultaneous write and read of the same address: behaviour is set by REGFILE_BYPASS_EN (see Optional Feature).
  - Write and read of different addresses do not interact.
- Arithmetic: none; widths are exact, with no extension or truncation.
  - Addresses are always in range (m bits addresses exactly 2**m entries).
- Out-of-reset hold: qa and qb read 0 until the first read.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read whose address equals waddr while write=1 returns the new write data in the same edge (write-first). Example: write reg3 <= 0x5A with read_a of addr 3 gives qa=0x5A next cycle.
- Undefined: that read returns the old contents (read-first). Same example gives the prior reg3 value; the new value is visible from the following read.

Decomposition:
- Shared package regfile_pkg:
  - constants REGFILE_N_DEFAULT=8 and REGFILE_M_DEFAULT=3.
  - localparam-style constant WD_SEL_DIN=1'b1 / WD_SEL_ALU=1'b0.
  - These are shared with the ALU and the future controller.
- One natural sub-module, regfile_read_port:
  - registered mux plus valid flop, plus the bypass compare when the macro is on.
  - instantiated twice (A, B).
- The storage array and write mux stay in the top module.

Test Plan:
- Reset: write reg[i]=i+1 for all i, assert rst=0 for one cycle, then read all addresses → every qa/qb = 0; valids 0 during and directly after reset.
- Load/read: wd_sel=1, din=0x7F to addr 2 and din=0x81 to addr 5, then read_a addr 2 and read_b addr 5 in the same cycle → next cycle qa=0x7F, qb=0x81, both valids 1.
- Write-back path: wd_sel=0, alu_sum=0x00, write addr 4, din=0xFF simultaneously → reg4=0x00 (alu_sum chosen, din ignored).
- Hold: read addr 2 (qa=0x7F), then read_a=0 for 3 cycles while writing addr 2 to 0x11 → qa stays 0x7F, qa_valid=0 for those cycles.
- Same-address collision: reg3=0x20, write 0x5A to addr 3 with read_a and read_b on addr 3 in the same cycle → with REGFILE_BYPASS_EN qa=qb=0x5A; without it qa=qb=0x20, then the next read gives 0x5A.
- Reset priority: write=1, addr 1, din=0xAA together with rst=0 → reg1 stays 0 and qa/qb=0 on the next read.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: constants shared by the operand register file, the ALU and
// the controller that drives them.
package regfile_pkg;

    // Default geometry; the data width must match the ALU width.
    localparam int REGFILE_N_DEFAULT = 8;
    localparam int REGFILE_M_DEFAULT = 3;

    // Write-data source select encoding.
    localparam logic WD_SEL_DIN = 1'b1;
    localparam logic WD_SEL_ALU = 1'b0;

    // Number of registers for a given address width.
    function automatic int regfile_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_if.sv
// regfile_if: bundle of the write port, the two read requests and the two
// registered operand outputs.
//
// Read handshake: a request is accepted on every rising edge where
// read_x=1 (there is no back-pressure). Exactly one cycle later qx_valid=1
// and qx carries the data for that request. When read_x=0, qx_valid falls
// to 0 on the next edge while qx keeps its last value.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int n = REGFILE_N_DEFAULT,
    parameter int m = REGFILE_M_DEFAULT
) ();

    logic         wd_sel;
    logic [n-1:0] din;
    logic [n-1:0] alu_sum;
    logic         write;
    logic [m-1:0] waddr;
    logic         read_a;
    logic [m-1:0] raddr_a;
    logic         read_b;
    logic [m-1:0] raddr_b;
    logic [n-1:0] qa;
    logic [n-1:0] qb;
    logic         qa_valid;
    logic         qb_valid;

    // Controller / stimulus side.
    modport master (
        output wd_sel, din, alu_sum, write, waddr,
        output read_a, raddr_a, read_b, raddr_b,
        input  qa, qb, qa_valid, qb_valid
    );

    // Register file side.
    modport slave (
        input  wd_sel, din, alu_sum, write, waddr,
        input  read_a, raddr_a, read_b, raddr_b,
        output qa, qb, qa_valid, qb_valid
    );

endinterface : regfile_if

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port (data register + valid flop).
// Optional macro REGFILE_BYPASS_EN: when defined, a read that hits the
// address being written in the same edge returns the new write data
// (write-first); when undefined it returns the stored contents (read-first).
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int n = REGFILE_N_DEFAULT,
    parameter int m = REGFILE_M_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         read,
    input  logic [m-1:0] raddr,
    input  logic [n-1:0] regs [2**m],
    input  logic         write,
    input  logic [m-1:0] waddr,
    input  logic [n-1:0] wdata,
    output logic [n-1:0] q,
    output logic         q_valid
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [n-1:0] q_d;
    logic [n-1:0] q_q;
    logic         q_valid_d;
    logic         q_valid_q;
    logic         wr_hit;

    // A read collides with the write when both target the same register.
    assign wr_hit = write && (waddr == raddr);

    // Next data/valid: load on a read request, otherwise hold data and drop valid.
    always_comb begin
        q_d       = q_q;
        q_valid_d = 1'b0;
        if (read) begin
            q_valid_d = 1'b1;
            if (BYPASS_EN && wr_hit) begin
                q_d = wdata;
            end else begin
                q_d = regs[raddr];
            end
        end
    end

    // Synchronous active-low reset clears the data and any pending result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule : regfile_read_port

// File: rtl/regfile.sv
// regfile: 2**m x n operand register file with one write port and two
// registered read ports feeding the ALU A/B operands.
// Optional macro REGFILE_BYPASS_EN selects write-first collision behaviour
// (see regfile_read_port); the default build is read-first.
module regfile
    import regfile_pkg::*;
#(
    parameter int n = REGFILE_N_DEFAULT,
    parameter int m = REGFILE_M_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    regfile_if.slave bus
);

    localparam int DEPTH = 2**m;

    logic [n-1:0] regs_d [DEPTH];
    logic [n-1:0] regs_q [DEPTH];
    logic [n-1:0] wdata;

    // Write-data source: external load path or ALU write-back.
    assign wdata = (bus.wd_sel == WD_SEL_DIN) ? bus.din : bus.alu_sum;

    // Next storage contents: only the addressed register changes on a write.
    always_comb begin
        regs_d = regs_q;
        if (bus.write) begin
            regs_d[bus.waddr] = wdata;
        end
    end

    // Storage array; reset clears every register and overrides a write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(.n(n), .m(m)) u_port_a (
        .clk     (clk),
        .rst     (rst),
        .read    (bus.read_a),
        .raddr   (bus.raddr_a),
        .regs    (regs_q),
        .write   (bus.write),
        .waddr   (bus.waddr),
        .wdata   (wdata),
        .q       (bus.qa),
        .q_valid (bus.qa_valid)
    );

    regfile_read_port #(.n(n), .m(m)) u_port_b (
        .clk     (clk),
        .rst     (rst),
        .read    (bus.read_b),
        .raddr   (bus.raddr_b),
        .regs    (regs_q),
        .write   (bus.write),
        .waddr   (bus.waddr),
        .wdata   (wdata),
        .q       (bus.qb),
        .q_valid (bus.qb_valid)
    );

endmodule : regfile
